// File: rtl/alu_reg_file_pkg.sv
// Shared definitions for the MIPS-I execution core: function codes of the
// integer ALU and register file geometry.
package alu_reg_file_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam logic [ADDR_W-1:0] REG_V0 = 5'd2;

    typedef enum logic [5:0] {
        FUNCT_SLL  = 6'h00,
        FUNCT_SRL  = 6'h02,
        FUNCT_SRA  = 6'h03,
        FUNCT_SLLV = 6'h04,
        FUNCT_SRLV = 6'h06,
        FUNCT_SRAV = 6'h07,
        FUNCT_JR   = 6'h08,
        FUNCT_ADDU = 6'h21,
        FUNCT_SUBU = 6'h23,
        FUNCT_AND  = 6'h24,
        FUNCT_OR   = 6'h25,
        FUNCT_XOR  = 6'h26,
        FUNCT_NOR  = 6'h27,
        FUNCT_SLT  = 6'h2A,
        FUNCT_SLTU = 6'h2B
    } funct_t;

endpackage : alu_reg_file_pkg

// File: rtl/alu_reg_file_reg_file.sv
// 32x32 register file: two combinational read ports, one write port, $2 tap.
// $0 is hard-wired to zero. Optional write-to-read bypass: ALU_REG_FILE_BYPASS_EN.
module reg_file
    import alu_reg_file_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic                write,
    input  logic [XLEN-1:0]     data_in,
    output logic [XLEN-1:0]     a,
    output logic [XLEN-1:0]     b,
    output logic [XLEN-1:0]     register_v0
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic            wr_en;

    assign wr_en = write && (write_addr != '0);

    // NOTE: the whole array sits on the async reset because every register
    // must read 0 after reset; this forces flops instead of a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking so every read this cycle still sees the old value.
            regs_q[write_addr] <= data_in;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [XLEN-1:0] val;
        val = (addr == '0) ? '0 : regs_q[addr];
`ifdef ALU_REG_FILE_BYPASS_EN
        // Forwarding stays off under reset so reads are 0 immediately.
        if (reset && wr_en && (write_addr == addr)) begin
            val = data_in;
        end
`endif
        return val;
    endfunction

    assign a           = read_port(addr_a);
    assign b           = read_port(addr_b);
    assign register_v0 = read_port(REG_V0);

endmodule : reg_file

// File: rtl/alu_reg_file.sv
// MIPS-I execution core: combinational integer ALU fused with the register file.
// Build option ALU_REG_FILE_BYPASS_EN forwards write data to the read ports.
module alu_reg_file
    import alu_reg_file_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr_a,
    input  logic [4:0]  addr_b,
    input  logic [4:0]  write_addr,
    input  logic        write,
    input  logic [31:0] data_in,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] register_v0,
    input  logic [31:0] alu_b,
    input  logic [5:0]  fncode,
    input  logic [4:0]  shamt,
    output logic [31:0] r
);

    reg_file u_reg_file (
        .clk         (clk),
        .reset       (reset),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .write_addr  (write_addr),
        .write       (write),
        .data_in     (data_in),
        .a           (a),
        .b           (b),
        .register_v0 (register_v0)
    );

    always_comb begin
        // NOTE: default first so unlisted codes yield 0 and no latch is inferred.
        r = '0;
        case (fncode)
            FUNCT_SLL:  r = alu_b << shamt;
            FUNCT_SRL:  r = alu_b >> shamt;
            FUNCT_SRA:  r = $unsigned($signed(alu_b) >>> shamt);
            FUNCT_SLLV: r = alu_b << a[4:0];
            FUNCT_SRLV: r = alu_b >> a[4:0];
            FUNCT_SRAV: r = $unsigned($signed(alu_b) >>> a[4:0]);
            FUNCT_ADDU: r = a + alu_b;
            FUNCT_SUBU: r = a - alu_b;
            FUNCT_AND:  r = a & alu_b;
            FUNCT_OR:   r = a | alu_b;
            FUNCT_XOR:  r = a ^ alu_b;
            FUNCT_NOR:  r = ~(a | alu_b);
            FUNCT_SLT:  r = {31'd0, $signed(a) < $signed(alu_b)};
            FUNCT_SLTU: r = {31'd0, a < alu_b};
            default:    r = '0;
        endcase
    end

endmodule : alu_reg_file

// File: tb/tb_alu_reg_file.sv
// Self-checking bench for alu_reg_file: directed cases plus randomized
// traffic checked against an array-based reference model.
module tb_alu_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  addr_a, addr_b, write_addr, shamt;
    logic        write;
    logic [31:0] data_in, alu_b;
    logic [5:0]  fncode;
    logic [31:0] a, b, register_v0, r;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_regs [32];

    alu_reg_file dut (
        .clk         (clk),
        .reset       (reset),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .write_addr  (write_addr),
        .write       (write),
        .data_in     (data_in),
        .a           (a),
        .b           (b),
        .register_v0 (register_v0),
        .alu_b       (alu_b),
        .fncode      (fncode),
        .shamt       (shamt),
        .r           (r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference ALU built from the instruction definitions.
    function automatic logic [31:0] model_alu(input logic [31:0] opa, input logic [31:0] opb,
                                              input logic [4:0] sh, input logic [5:0] fn);
        logic [31:0] res;
        int unsigned amt;
        res = 32'd0;
        amt = (fn == 6'h04 || fn == 6'h06 || fn == 6'h07) ? int'(opa % 32) : int'(sh);
        case (fn)
            6'h21: res = opa + opb;
            6'h23: res = opa - opb;
            6'h24: res = opa & opb;
            6'h25: res = opa | opb;
            6'h26: res = opa ^ opb;
            6'h27: res = ~(opa | opb);
            6'h2A: res = (int'(opa) < int'(opb)) ? 32'd1 : 32'd0;
            6'h2B: res = (longint'(opa) < longint'(opb)) ? 32'd1 : 32'd0;
            6'h00, 6'h04: res = opb * (32'd1 << amt);
            6'h02, 6'h06: res = opb / (32'd1 << amt);
            6'h03, 6'h07: begin
                res = opb;
                for (int k = 0; k < int'(amt); k++) res = {res[31], res[31:1]};
            end
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
`ifdef ALU_REG_FILE_BYPASS_EN
        if (reset && write && write_addr == addr) return data_in;
`endif
        return ref_regs[addr];
    endfunction

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        write_addr = addr;
        data_in    = data;
        write      = 1'b1;
        @(posedge clk);
        if (reset && addr != 5'd0) ref_regs[addr] = data;
        #1;
        write = 1'b0;
    endtask

    task automatic alu_check(input string tag, input logic [4:0] ra, input logic [31:0] bv,
                             input logic [4:0] sh, input logic [5:0] fn, input logic [31:0] exp);
        addr_a = ra; alu_b = bv; shamt = sh; fncode = fn;
        #1;
        check(tag, r, exp);
    endtask

    initial begin
        logic [31:0] old3;
        logic [5:0]  legal [15];
        legal = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23,
                  6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08};
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        reset = 1'b0; write = 1'b0; write_addr = '0; data_in = '0;
        addr_a = 5'd1; addr_b = 5'd2; alu_b = '0; fncode = 6'h21; shamt = '0;

        // Reset state
        #2;
        check("reset_a", a, 32'd0);
        check("reset_b", b, 32'd0);
        check("reset_v0", register_v0, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Fill every register, then read back a sample
        for (int i = 0; i < 32; i++) do_write(5'(i), $urandom);
        for (int i = 0; i < 8; i++) begin
            addr_a = 5'($urandom); addr_b = 5'($urandom);
            #1;
            check("fill_a", a, ref_regs[addr_a]);
            check("fill_b", b, ref_regs[addr_b]);
        end

        // Asynchronous reset mid-cycle, then write attempt while held
        addr_a = 5'd7; addr_b = 5'd31;
        #2 reset = 1'b0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        #1;
        check("areset_a", a, 32'd0);
        check("areset_b", b, 32'd0);
        check("areset_v0", register_v0, 32'd0);
        do_write(5'd5, 32'hA5A5A5A5);
        addr_a = 5'd5;
        #1 reset = 1'b1;
        #1 check("write_in_reset", a, 32'd0);

        // Basic write/read and $0 rule
        do_write(5'd2, 32'hDEADBEEF);
        check("v0_write", register_v0, 32'hDEADBEEF);
        do_write(5'd0, 32'd7);
        addr_a = 5'd0;
        #1 check("r0_zero", a, 32'd0);

        // Directed ALU corner cases
        do_write(5'd1, 32'hFFFFFFFF);
        alu_check("addu_wrap", 5'd1, 32'd1, 5'd0, 6'h21, 32'd0);
        alu_check("subu_wrap", 5'd0, 32'd1, 5'd0, 6'h23, 32'hFFFFFFFF);
        do_write(5'd1, 32'hFFFFFFFE);
        alu_check("slt", 5'd1, 32'd1, 5'd0, 6'h2A, 32'd1);
        alu_check("sltu", 5'd1, 32'd1, 5'd0, 6'h2B, 32'd0);
        alu_check("sra", 5'd1, 32'h80000000, 5'd4, 6'h03, 32'hF8000000);
        alu_check("srl", 5'd1, 32'h80000000, 5'd4, 6'h02, 32'h08000000);
        alu_check("illegal", 5'd1, 32'h80000000, 5'd4, 6'h3F, 32'd0);
        alu_check("jr_zero", 5'd1, 32'h12345678, 5'd4, 6'h08, 32'd0);

        // Same-cycle read of the register being written
        old3 = ref_regs[3];
        addr_a = 5'd3; write_addr = 5'd3; data_in = 32'h1234; write = 1'b1;
        #1;
`ifdef ALU_REG_FILE_BYPASS_EN
        check("same_cycle_a", a, 32'h1234);
`else
        check("same_cycle_a", a, old3);
`endif
        @(posedge clk);
        ref_regs[3] = 32'h1234;
        #1 write = 1'b0;
        check("after_edge_a", a, 32'h1234);

        // Randomized traffic against the reference model
        for (int it = 0; it < 300; it++) begin
            addr_a     = 5'($urandom);
            addr_b     = 5'($urandom);
            write_addr = ($urandom_range(0, 3) == 0) ? addr_a : 5'($urandom);
            write      = 1'($urandom);
            data_in    = ($urandom_range(0, 3) == 0) ? 32'h80000000 | $urandom_range(0, 7) : $urandom;
            alu_b      = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
            shamt      = 5'($urandom);
            fncode     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 14)];
            #1;
            check("rnd_a", a, model_read(addr_a));
            check("rnd_b", b, model_read(addr_b));
            check("rnd_v0", register_v0, model_read(5'd2));
            check("rnd_r", r, model_alu(model_read(addr_a), alu_b, shamt, fncode));
            @(posedge clk);
            if (write && write_addr != 5'd0) ref_regs[write_addr] = data_in;
            #1 write = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_reg_file
